// File: rtl/chdr_conv_arbiter.sv
// chdr_conv_arbiter
// -----------------------------------------------------------------------------
// Packet-granular 2:1 arbiter that shares one CHDR sample-format converter
// between two CHDR input streams. It grants one input for a whole packet, from
// the header beat through tlast, then goes back to IDLE and arbitrates again.
// Arbitration is round-robin by default, or fixed priority to port 0.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   i0_* / i1_*              CHDR input streams (64-bit tdata, tvalid, tlast,
//                            tready back to the source)
//   o_*                      CHDR stream to the converter's slave port
//   set_stb/addr/data        settings bus; control register at BASE holds
//                            {fixed_prio, en1, en0} in bits [2:0]
//   pkt_cnt0, pkt_cnt1       per-port completed-packet counters (wrapping)
//   busy                     high while a packet is granted
// -----------------------------------------------------------------------------
module chdr_conv_arbiter #(
    parameter logic [7:0]  BASE  = 8'd0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      i0_tdata,
    input  logic             i0_tvalid,
    input  logic             i0_tlast,
    output logic             i0_tready,
    input  logic [63:0]      i1_tdata,
    input  logic             i1_tvalid,
    input  logic             i1_tlast,
    output logic             i1_tready,
    output logic [63:0]      o_tdata,
    output logic             o_tvalid,
    output logic             o_tlast,
    input  logic             o_tready,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state_reg;
    logic       last_grant_reg;
    logic [2:0] ctrl_reg;
    logic       en0, en1, fixed_prio;
    logic       req0, req1;
    logic       pkt_done;
    logic [1:0] granted;

    // Only the low three bits of the control word are meaningful.
    logic unused_set_data;
    assign unused_set_data = ^set_data[31:3];

    assign en0        = ctrl_reg[0];
    assign en1        = ctrl_reg[1];
    assign fixed_prio = ctrl_reg[2];

    // Requests are only looked at in IDLE, so disabling a port mid-packet
    // never truncates the packet in flight.
    assign req0 = en0 && i0_tvalid;
    assign req1 = en1 && i1_tvalid;

    assign granted[0] = (state_reg == GRANT0);
    assign granted[1] = (state_reg == GRANT1);
    assign busy       = (state_reg != IDLE);

    // Control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg <= 3'b011;
        end else if (set_stb && (set_addr == BASE)) begin
            ctrl_reg <= set_data[2:0];
        end
    end

    // Zero-latency data path: the granted input is wired straight through.
    // In IDLE nothing is valid and nothing is ready, so no beat can move.
    always_comb begin
        o_tdata   = 64'd0;
        o_tvalid  = 1'b0;
        o_tlast   = 1'b0;
        i0_tready = 1'b0;
        i1_tready = 1'b0;
        case (state_reg)
            GRANT0: begin
                o_tdata   = i0_tdata;
                o_tvalid  = i0_tvalid;
                o_tlast   = i0_tlast;
                i0_tready = o_tready;
            end
            GRANT1: begin
                o_tdata   = i1_tdata;
                o_tvalid  = i1_tvalid;
                o_tlast   = i1_tlast;
                i1_tready = o_tready;
            end
            default: ;
        endcase
        pkt_done = o_tvalid && o_tready && o_tlast;
    end

    // Arbitration FSM. Returning to IDLE after every tlast costs one bubble
    // cycle per packet but keeps the grant decision fully registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;   // port 0 wins the first tie
        end else begin
            case (state_reg)
                IDLE: begin
                    // Port 0 wins when alone, under fixed priority, or when
                    // port 1 had the previous grant.
                    if (req0 && (!req1 || fixed_prio || last_grant_reg)) begin
                        state_reg <= GRANT0;
                    end else if (req1) begin
                        state_reg <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (pkt_done) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b0;
                    end
                end
                GRANT1: begin
                    if (pkt_done) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-port completed-packet counters, wrapping modulo 2^CNT_W.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (granted[gi] && pkt_done) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign pkt_cnt0 = g_cnt[0].cnt_reg;
    assign pkt_cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_chdr_conv_arbiter.sv
// Directed testbench for chdr_conv_arbiter. Each task drives one scenario and
// checks DUT outputs a couple of time units after the rising edge.
module tb_chdr_conv_arbiter;

    localparam logic [7:0] BASE  = 8'h40;
    localparam int         CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      i0_tdata, i1_tdata, o_tdata;
    logic             i0_tvalid, i0_tlast, i0_tready;
    logic             i1_tvalid, i1_tlast, i1_tready;
    logic             o_tvalid, o_tlast, o_tready;
    logic             set_stb;
    logic [7:0]       set_addr;
    logic [31:0]      set_data;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chdr_conv_arbiter #(.BASE(BASE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i0_tdata(i0_tdata), .i0_tvalid(i0_tvalid), .i0_tlast(i0_tlast), .i0_tready(i0_tready),
        .i1_tdata(i1_tdata), .i1_tvalid(i1_tvalid), .i1_tlast(i1_tlast), .i1_tready(i1_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
    );

    function automatic logic [63:0] mk(input int port, input int pkt, input int beat);
        logic [15:0] p16, b16;
        p16 = pkt[15:0];
        b16 = beat[15:0];
        return {24'hC0DE00, port[7:0], p16, b16};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i0_tdata = '0; i0_tvalid = 0; i0_tlast = 0;
        i1_tdata = '0; i1_tvalid = 0; i1_tlast = 0;
        o_tready = 1; set_stb = 0; set_addr = '0; set_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic write_ctrl(input logic [31:0] val);
        set_stb = 1; set_addr = BASE; set_data = val;
        tick();
        set_stb = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        i0_tvalid = 1; i1_tvalid = 1;
        #3;
        n_tests++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_o_tvalid got=%b exp=0", o_tvalid); end
        n_tests++; if ({i0_tready, i1_tready} !== 2'b00) begin n_fail++; $display("FAIL reset_tready got=%b exp=00", {i0_tready, i1_tready}); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if ({pkt_cnt0, pkt_cnt1} !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got=%h/%h exp=0/0", pkt_cnt0, pkt_cnt1); end
        n_tests++; if ({o_tdata, o_tlast} !== 65'd0) begin n_fail++; $display("FAIL reset_data got=%h/%b exp=0/0", o_tdata, o_tlast); end
        $display("[TB] reset: outputs idle, counters zero");
        do_reset();
    endtask

    task automatic test_round_robin;
        int exp_g[16];
        int b0 = 0, b1 = 0, p0 = 0, p1 = 0, obs;
        logic hs0, hs1;
        exp_g = '{2, 0, 0, 0, 2, 1, 1, 1, 2, 0, 0, 0, 2, 1, 1, 1};
        do_reset();
        for (int c = 0; c < 16; c++) begin
            i0_tdata = mk(0, p0, b0); i0_tvalid = 1; i0_tlast = (b0 == 2);
            i1_tdata = mk(1, p1, b1); i1_tvalid = 1; i1_tlast = (b1 == 2);
            o_tready = 1;
            #1;
            obs = i0_tready ? 0 : (i1_tready ? 1 : 2);
            n_tests++;
            if (obs != exp_g[c]) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%0d exp=%0d", c, obs, exp_g[c]); end
            if (exp_g[c] == 0) begin
                n_tests++;
                if (o_tdata !== mk(0, p0, b0) || o_tlast !== (b0 == 2)) begin
                    n_fail++; $display("FAIL rr_data0 cyc=%0d got=%h exp=%h", c, o_tdata, mk(0, p0, b0));
                end
            end else if (exp_g[c] == 1) begin
                n_tests++;
                if (o_tdata !== mk(1, p1, b1) || o_tlast !== (b1 == 2)) begin
                    n_fail++; $display("FAIL rr_data1 cyc=%0d got=%h exp=%h", c, o_tdata, mk(1, p1, b1));
                end
            end else begin
                n_tests++;
                if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble cyc=%0d o_tvalid got=%b exp=0", c, o_tvalid); end
            end
            hs0 = i0_tvalid && i0_tready;
            hs1 = i1_tvalid && i1_tready;
            tick();
            if (hs0) begin if (b0 == 2) begin b0 = 0; p0++; end else b0++; end
            if (hs1) begin if (b1 == 2) begin b1 = 0; p1++; end else b1++; end
        end
        n_tests++; if (pkt_cnt0 !== 4'd2 || pkt_cnt1 !== 4'd2) begin n_fail++; $display("FAIL rr_counts got=%0d/%0d exp=2/2", pkt_cnt0, pkt_cnt1); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_end got=%b exp=0", busy); end
        $display("[TB] round_robin: 4 packets, counts %0d/%0d", pkt_cnt0, pkt_cnt1);
    endtask

    task automatic test_fixed_prio;
        int b0 = 0, p0 = 0;
        logic hs0;
        do_reset();
        write_ctrl(32'h0000_0007);
        for (int c = 0; c < 12; c++) begin
            i0_tdata = mk(0, p0, b0); i0_tvalid = 1; i0_tlast = (b0 == 2);
            i1_tdata = mk(1, 0, 0);   i1_tvalid = 1; i1_tlast = 0;
            #1;
            n_tests++;
            if (i1_tready !== 1'b0) begin n_fail++; $display("FAIL fp_port1_ready cyc=%0d got=%b exp=0", c, i1_tready); end
            hs0 = i0_tvalid && i0_tready;
            tick();
            if (hs0) begin if (b0 == 2) begin b0 = 0; p0++; end else b0++; end
        end
        n_tests++; if (pkt_cnt0 !== 4'd3 || pkt_cnt1 !== 4'd0) begin n_fail++; $display("FAIL fp_counts got=%0d/%0d exp=3/0", pkt_cnt0, pkt_cnt1); end
        i0_tvalid = 0;
        #1;
        n_tests++; if (i1_tready !== 1'b0) begin n_fail++; $display("FAIL fp_idle_ready got=%b exp=0", i1_tready); end
        tick();
        n_tests++;
        if (i1_tready !== 1'b1 || o_tvalid !== 1'b1 || o_tdata !== mk(1, 0, 0)) begin
            n_fail++; $display("FAIL fp_port1_grant got=ready %b data %h exp=ready 1 data %h", i1_tready, o_tdata, mk(1, 0, 0));
        end
        $display("[TB] fixed_prio: port0 3 packets, port1 granted after port0 idle");
    endtask

    task automatic test_backpressure;
        int b1 = 0, lasts = 0;
        logic hs1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            i1_tdata = mk(1, 0, b1); i1_tvalid = (b1 < 4); i1_tlast = (b1 == 3);
            o_tready = (c == 0) ? 1'b1 : ((c % 2) == 1);
            #1;
            if (c == 0) begin
                n_tests++; if (i1_tready !== 1'b0) begin n_fail++; $display("FAIL bp_idle_ready got=%b exp=0", i1_tready); end
            end else begin
                n_tests++; if (i1_tready !== o_tready) begin n_fail++; $display("FAIL bp_mirror cyc=%0d got=%b exp=%b", c, i1_tready, o_tready); end
            end
            n_tests++; if (i0_tready !== 1'b0) begin n_fail++; $display("FAIL bp_port0_ready cyc=%0d got=%b exp=0", c, i0_tready); end
            hs1 = i1_tvalid && i1_tready;
            if (hs1) begin
                n_tests++;
                if (o_tdata !== mk(1, 0, b1)) begin n_fail++; $display("FAIL bp_order cyc=%0d got=%h exp=%h", c, o_tdata, mk(1, 0, b1)); end
                if (o_tlast) lasts++;
            end
            tick();
            if (hs1) b1++;
        end
        n_tests++; if (b1 != 4 || lasts != 1) begin n_fail++; $display("FAIL bp_beats got=%0d beats %0d lasts exp=4 beats 1 last", b1, lasts); end
        n_tests++; if (pkt_cnt1 !== 4'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_done got=cnt %0d busy %b exp=cnt 1 busy 0", pkt_cnt1, busy); end
        $display("[TB] backpressure: 4 beats in order, %0d tlast", lasts);
    endtask

    task automatic test_enable_change;
        int b1 = 0;
        logic hs1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            i1_tdata = mk(1, 0, b1); i1_tvalid = 1; i1_tlast = (b1 == 3);
            if (c == 2) begin set_stb = 1; set_addr = BASE; set_data = 32'hFFFF_FFF9; end
            else set_stb = 0;
            #1;
            if (c == 4) begin
                n_tests++;
                if (i1_tready !== 1'b1 || o_tlast !== 1'b1) begin
                    n_fail++; $display("FAIL en_completes got=ready %b last %b exp=1 1", i1_tready, o_tlast);
                end
            end
            hs1 = i1_tvalid && i1_tready;
            tick();
            if (hs1) b1++;
        end
        set_stb = 0;
        n_tests++; if (pkt_cnt1 !== 4'd1) begin n_fail++; $display("FAIL en_count got=%0d exp=1", pkt_cnt1); end
        i1_tdata = mk(1, 1, 0); i1_tvalid = 1; i1_tlast = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if (i1_tready !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL en_ignored cyc=%0d got=ready %b busy %b exp=0 0", c, i1_tready, busy);
            end
            tick();
        end
        $display("[TB] enable_change: packet finished, port1 then ignored");
    endtask

    task automatic test_single_beat_wrap;
        do_reset();
        i0_tdata = mk(0, 0, 0); i0_tvalid = 1; i0_tlast = 1; o_tready = 1;
        for (int c = 0; c < 34; c++) begin
            if (c == 32) begin
                #1;
                n_tests++; if (pkt_cnt0 !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got=%0d exp=0", pkt_cnt0); end
            end
            if (c == 1) begin
                #1;
                n_tests++; if (i0_tready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL sb_grant got=ready %b busy %b exp=1 1", i0_tready, busy); end
            end
            tick();
        end
        i0_tvalid = 0;
        n_tests++; if (pkt_cnt0 !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got=%0d exp=1", pkt_cnt0); end
        $display("[TB] single_beat_wrap: 17 packets, cnt0=%0d", pkt_cnt0);
    endtask

    task automatic test_async_reset;
        int b0 = 0;
        logic hs0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            i0_tdata = mk(0, 0, b0); i0_tvalid = 1; i0_tlast = (b0 == 2); o_tready = 1;
            #1;
            hs0 = i0_tvalid && i0_tready;
            tick();
            if (hs0) b0 = (b0 == 2) ? 0 : b0 + 1;
        end
        i0_tdata = mk(0, 1, b0); i0_tlast = (b0 == 2);
        #1;
        n_tests++; if (o_tvalid !== 1'b1 || pkt_cnt0 !== 4'd1) begin n_fail++; $display("FAIL ar_pre got=valid %b cnt %0d exp=1 1", o_tvalid, pkt_cnt0); end
        #2 rst = 1;
        #1;
        n_tests++; if (o_tvalid !== 1'b0 || i0_tready !== 1'b0 || i1_tready !== 1'b0) begin
            n_fail++; $display("FAIL ar_drop got=valid %b rdy %b%b exp=0 00", o_tvalid, i0_tready, i1_tready);
        end
        n_tests++; if (busy !== 1'b0 || pkt_cnt0 !== 4'd0 || pkt_cnt1 !== 4'd0) begin
            n_fail++; $display("FAIL ar_state got=busy %b cnt %0d/%0d exp=0 0/0", busy, pkt_cnt0, pkt_cnt1);
        end
        tick();
        rst = 0;
        idle_inputs();
        $display("[TB] async_reset: outputs dropped before next edge");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_fixed_prio();
        test_backpressure();
        test_enable_change();
        test_single_beat_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
